eject_collector: RTL and testbench

- Node-side sink for the six router eject links; the counterpart to the per-node injection ports of the 16-node collective network.
- Absorbs ejected 85-bit packets without backpressure, buffers them per direction, and serialises them round-robin onto a single valid/ready stream for the node.
- Counts delivered packets of one armed collective opcode and raises done when the expected number has arrived.

---
 rtl/eject_collector.sv | 190 +++++++++++++++++++
 tb/tb_eject_collector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/eject_collector.sv
// Node-side eject sink: six per-direction FIFOs merged round-robin onto one
// valid/ready stream, plus a counter that flags arrival of an armed collective.
module eject_collector #(
   parameter int PKT_W      = 85,
   parameter int FIFO_DEPTH = 4,
   parameter int COUNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PKT_W-1:0]   in_xpos_eject,
   input  logic [PKT_W-1:0]   in_ypos_eject,
   input  logic [PKT_W-1:0]   in_zpos_eject,
   input  logic [PKT_W-1:0]   in_xneg_eject,
   input  logic [PKT_W-1:0]   in_yneg_eject,
   input  logic [PKT_W-1:0]   in_zneg_eject,
   input  logic               expect_load,
   input  logic [3:0]         expect_op,
   input  logic [COUNT_W-1:0] expect_count,
   output logic [PKT_W-1:0]   out_pkt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [COUNT_W-1:0] rcv_count,
   output logic               done,
   output logic [5:0]         overflow
);

   localparam int NP = 6;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [PKT_W-1:0]   w_in [NP];
   logic [PKT_W-1:0]   r_mem [NP][FIFO_DEPTH];
   logic [AW-1:0]      r_wptr [NP];
   logic [AW-1:0]      r_rptr [NP];
   logic [CW-1:0]      r_cnt [NP];
   logic [NP-1:0]      w_nonempty, w_full, w_wr, w_pop, w_drop;
   logic [2:0]         r_rr_ptr;
   logic [3:0]         w_idx;
   logic [2:0]         w_gnt_idx;
   logic               w_gnt_vld;
   logic               w_adv;
   logic [PKT_W-1:0]   w_rd_data;
   logic [PKT_W-1:0]   r_out_pkt;
   logic               r_out_valid;
   logic [5:0]         r_ovf;
   logic [1:0]         r_state;
   logic [3:0]         r_op;
   logic [COUNT_W-1:0] r_exp;
   logic [COUNT_W-1:0] r_rcv;
   logic [COUNT_W-1:0] w_rcv_inc;
   logic               r_done;
   logic               w_hs;
   logic               w_match;

   assign w_in[0] = in_xpos_eject;
   assign w_in[1] = in_ypos_eject;
   assign w_in[2] = in_zpos_eject;
   assign w_in[3] = in_xneg_eject;
   assign w_in[4] = in_yneg_eject;
   assign w_in[5] = in_zneg_eject;

   assign w_adv     = ~r_out_valid | out_ready;
   assign w_rd_data = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

   // FIFO occupancy flags
   always_comb begin
      w_nonempty = '0;
      w_full     = '0;
      for (int i = 0; i < NP; i++) begin
         w_nonempty[i] = (r_cnt[i] != '0);
         w_full[i]     = (r_cnt[i] == CW'(FIFO_DEPTH));
      end
   end

   // Round-robin pick; scanning from the far end lets the nearest requester win
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = 3'd0;
      w_idx     = 4'd0;
      w_pop     = '0;
      for (int k = NP - 1; k >= 0; k--) begin
         w_idx     = {1'b0, r_rr_ptr} + 4'(k);
         w_idx     = (w_idx >= 4'(NP)) ? (w_idx - 4'(NP)) : w_idx;
         w_gnt_vld = w_gnt_vld | w_nonempty[w_idx[2:0]];
         w_gnt_idx = w_nonempty[w_idx[2:0]] ? w_idx[2:0] : w_gnt_idx;
      end
      w_pop[w_gnt_idx] = w_gnt_vld & w_adv;
   end

   // Write enables; a full FIFO being popped this cycle still has room
   always_comb begin
      w_wr   = '0;
      w_drop = '0;
      for (int i = 0; i < NP; i++) begin
         w_wr[i]   = w_in[i][PKT_W-1] & (~w_full[i] | w_pop[i]);
         w_drop[i] = w_in[i][PKT_W-1] & w_full[i] & ~w_pop[i];
      end
   end

   // FIFO storage (no reset needed; occupancy is tracked separately)
   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (w_wr[i]) r_mem[i][r_wptr[i]] <= w_in[i];
      end
   end

   // FIFO pointers, occupancy and sticky drop flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NP; i++) begin
            r_wptr[i] <= '0;
            r_rptr[i] <= '0;
            r_cnt[i]  <= '0;
         end
         r_ovf <= 6'b000000;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (w_wr[i])   r_wptr[i] <= r_wptr[i] + AW'(1);
            if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
            r_cnt[i] <= r_cnt[i] + CW'(w_wr[i]) - CW'(w_pop[i]);
            if (w_drop[i]) r_ovf[i] <= 1'b1;
         end
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_pkt   <= '0;
         r_out_valid <= 1'b0;
         r_rr_ptr    <= 3'd0;
      end else if (w_adv) begin
         r_out_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_out_pkt <= w_rd_data;
            r_rr_ptr  <= (w_gnt_idx == 3'(NP - 1)) ? 3'd0 : (w_gnt_idx + 3'd1);
         end
      end
   end

   assign w_hs      = r_out_valid & out_ready;
   assign w_match   = (r_out_pkt[PKT_W-2 -: 4] == r_op);
   assign w_rcv_inc = (r_rcv == '1) ? r_rcv : (r_rcv + COUNT_W'(1));

   // Collective counter FSM; a load re-arms from any state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_op    <= 4'd0;
         r_exp   <= '0;
         r_rcv   <= '0;
         r_done  <= 1'b0;
      end else if (expect_load) begin
         r_op    <= expect_op;
         r_exp   <= expect_count;
         r_rcv   <= '0;
         r_state <= (expect_count == '0) ? S_DONE : S_COUNT;
         r_done  <= (expect_count == '0);
      end else begin
         case (r_state)
            S_IDLE: r_done <= 1'b0;
            S_COUNT: begin
               if (w_hs && w_match) begin
                  r_rcv <= w_rcv_inc;
                  if (w_rcv_inc == r_exp) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: r_done <= 1'b1;
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign out_pkt   = r_out_pkt;
   assign out_valid = r_out_valid;
   assign rcv_count = r_rcv;
   assign done      = r_done;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_eject_collector.sv
// Directed self-checking bench for eject_collector.
module tb_eject_collector;

   logic          clk;
   logic          rst;
   logic [84:0]   in_xpos, in_ypos, in_zpos, in_xneg, in_yneg, in_zneg;
   logic          expect_load;
   logic [3:0]    expect_op;
   logic [7:0]    expect_count;
   logic [84:0]   out_pkt;
   logic          out_valid;
   logic          out_ready;
   logic [7:0]    rcv_count;
   logic          done;
   logic [5:0]    overflow;

   int n_cmp  = 0;
   int n_fail = 0;

   eject_collector dut (
      .clk           (clk),
      .rst           (rst),
      .in_xpos_eject (in_xpos),
      .in_ypos_eject (in_ypos),
      .in_zpos_eject (in_zpos),
      .in_xneg_eject (in_xneg),
      .in_yneg_eject (in_yneg),
      .in_zneg_eject (in_zneg),
      .expect_load   (expect_load),
      .expect_op     (expect_op),
      .expect_count  (expect_count),
      .out_pkt       (out_pkt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .rcv_count     (rcv_count),
      .done          (done),
      .overflow      (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [84:0] mk(input logic [3:0] op, input logic [79:0] pl);
      return {1'b1, op, pl};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [84:0] p1;
   logic [84:0] p2 [6];
   logic [84:0] p3 [6];
   logic [84:0] q4 [4];
   logic [84:0] sb [$];
   logic [84:0] hold, pk, exp_pk;
   logic        have_hold;
   int          beats, id, seen;

   initial begin
      rst = 1'b0;
      in_xpos = '0; in_ypos = '0; in_zpos = '0;
      in_xneg = '0; in_yneg = '0; in_zneg = '0;
      expect_load = 1'b0; expect_op = 4'd0; expect_count = 8'd0;
      out_ready = 1'b0;
      #1;
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_pkt",   128'(out_pkt),   128'(0));
      check("rst_rcv",   128'(rcv_count), 128'(0));
      check("rst_done",  128'(done),      128'(0));
      check("rst_ovf",   128'(overflow),  128'(0));
      tick(); tick();
      rst = 1'b1;
      tick();

      // single flit on zneg
      out_ready = 1'b1;
      p1 = mk(4'b1100, 80'h1234_5678);
      in_zneg = p1;
      tick();
      in_zneg = '0;
      check("t1_lat_k",   128'(out_valid), 128'(0));
      tick();
      check("t1_valid",   128'(out_valid), 128'(1));
      check("t1_pkt",     128'(out_pkt),   128'(p1));
      tick();
      check("t1_one_hs",  128'(out_valid), 128'(0));

      // all six ports in one cycle
      for (int i = 0; i < 6; i++) p2[i] = mk(4'(i + 3), 80'(32'hA0 + i));
      in_xpos = p2[0]; in_ypos = p2[1]; in_zpos = p2[2];
      in_xneg = p2[3]; in_yneg = p2[4]; in_zneg = p2[5];
      tick();
      in_xpos = '0; in_ypos = '0; in_zpos = '0;
      in_xneg = '0; in_yneg = '0; in_zneg = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("t2_valid%0d", i), 128'(out_valid), 128'(1));
         check($sformatf("t2_pkt%0d", i),   128'(out_pkt),   128'(p2[i]));
      end
      tick();
      check("t2_end",  128'(out_valid), 128'(0));
      check("t2_ovf",  128'(overflow),  128'(0));

      // overflow on xpos with output stalled
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         p3[i] = mk(4'b0110, 80'(32'h300 + i));
         in_xpos = p3[i];
         tick();
      end
      in_xpos = '0;
      check("t3_ovf",   128'(overflow),  128'(6'b000001));
      check("t3_valid", 128'(out_valid), 128'(1));
      check("t3_held",  128'(out_pkt),   128'(p3[0]));
      out_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) begin
            check($sformatf("t3_drain%0d", beats), 128'(out_pkt), 128'(p3[beats % 6]));
            beats++;
         end
         tick();
      end
      check("t3_beats", 128'(beats), 128'(5));

      // arm with zero count completes immediately
      expect_load = 1'b1; expect_op = 4'b1010; expect_count = 8'd0;
      tick();
      expect_load = 1'b0;
      check("t4_zero_done", 128'(done), 128'(1));

      // arm op=1111 count=3
      expect_load = 1'b1; expect_op = 4'b1111; expect_count = 8'd3;
      tick();
      expect_load = 1'b0;
      check("t4_arm_rcv",  128'(rcv_count), 128'(0));
      check("t4_arm_done", 128'(done),      128'(0));
      q4[0] = mk(4'b1111, 80'h41); q4[1] = mk(4'b0101, 80'h42);
      q4[2] = mk(4'b1111, 80'h43); q4[3] = mk(4'b1111, 80'h44);
      in_ypos = q4[0]; tick();
      in_ypos = q4[1]; tick();
      check("t4_pkt0", 128'(out_pkt), 128'(q4[0]));
      in_ypos = q4[2]; tick();
      check("t4_rcv1", 128'(rcv_count), 128'(1));
      in_ypos = q4[3]; tick();
      check("t4_rcv1b", 128'(rcv_count), 128'(1));
      in_ypos = '0; tick();
      check("t4_rcv2",  128'(rcv_count), 128'(2));
      check("t4_done0", 128'(done),      128'(0));
      tick();
      check("t4_rcv3",  128'(rcv_count), 128'(3));
      check("t4_done1", 128'(done),      128'(1));
      in_ypos = mk(4'b1111, 80'h45); tick();
      in_ypos = '0; tick(); tick();
      check("t4_nocount", 128'(rcv_count), 128'(3));
      check("t4_hold_done", 128'(done),    128'(1));

      // random backpressure against a scoreboard
      have_hold = 1'b0;
      hold = '0;
      id = 0;
      for (int c = 0; c < 220; c++) begin
         if (have_hold) begin
            check("t5_hold_v", 128'(out_valid), 128'(1));
            check("t5_hold_p", 128'(out_pkt),   128'(hold));
         end
         out_ready = (c >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            exp_pk = (sb.size() > 0) ? sb.pop_front() : '0;
            check("t5_pkt", 128'(out_pkt), 128'(exp_pk));
         end
         have_hold = out_valid && !out_ready;
         hold = out_pkt;
         if (c < 200 && sb.size() < 4 && $urandom_range(0, 1) == 1) begin
            pk = mk(4'b0010, 80'(32'h1000 + id));
            id++;
            in_xpos = pk;
            sb.push_back(pk);
         end else begin
            in_xpos = '0;
         end
         tick();
      end
      check("t5_left",  128'(sb.size()), 128'(0));
      check("t5_ovf",   128'(overflow),  128'(6'b000001));

      // reset mid-stream with packets buffered and FSM counting
      expect_load = 1'b1; expect_op = 4'b0111; expect_count = 8'd5;
      tick();
      expect_load = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_zpos = mk(4'b0111, 80'(32'h600 + i));
         tick();
      end
      in_zpos = '0;
      check("t6_pre_valid", 128'(out_valid), 128'(1));
      #2 rst = 1'b0;
      #1;
      check("t6_valid", 128'(out_valid), 128'(0));
      check("t6_pkt",   128'(out_pkt),   128'(0));
      check("t6_rcv",   128'(rcv_count), 128'(0));
      check("t6_done",  128'(done),      128'(0));
      check("t6_ovf",   128'(overflow),  128'(0));
      tick(); tick();
      rst = 1'b1;
      out_ready = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid) seen++;
      end
      check("t6_no_stale", 128'(seen), 128'(0));
      check("t6_done_after", 128'(done), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
